// File: rtl/pc_stack.sv
// Program counter with an integrated LIFO return-address stack.
// One operation per edge, priority ret > call > load > inc > hold, with sticky overflow/underflow flags.
module pc_stack #(
  parameter int               WIDTH        = 16,
  parameter int               DEPTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in,
  input  logic                     load,
  input  logic                     inc,
  input  logic                     call,
  input  logic                     ret,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         out,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] pc_q, pc_d, top, ret_addr;
  logic [AW:0]      sp_q, sp_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             push, ovf_evt, udf_evt;
  logic [AW-1:0]    rd_idx;

  assign full      = (sp_q == DEPTH_C);
  assign empty     = (sp_q == '0);
  assign depth     = sp_q;
  assign out       = pc_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

  // Top-of-stack read is only consumed when the stack is non-empty.
  assign rd_idx   = AW'(sp_q - 1'b1);
  assign top      = mem_q[rd_idx];
  assign ret_addr = pc_q + 1'b1;

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    push    = 1'b0;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (ret) begin
      if (!empty) begin
        pc_d = top;
        sp_d = sp_q - 1'b1;
      end else begin
        udf_evt = 1'b1;
      end
    end else if (call) begin
      pc_d = in;
      if (!full) begin
        push = 1'b1;
        sp_d = sp_q + 1'b1;
      end else begin
        ovf_evt = 1'b1;
      end
    end else if (load) begin
      pc_d = in;
    end else if (inc) begin
      pc_d = ret_addr;
    end
    // A new error on the clearing edge keeps its flag set.
    ovf_d = (ovf_q & ~clr_err) | ovf_evt;
    udf_d = (udf_q & ~clr_err) | udf_evt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Storage is not reset; sp_q alone governs what is visible.
  always_ff @(posedge clock) begin
    if (push) mem_q[sp_q[AW-1:0]] <= ret_addr;
  end
endmodule
